cla_nbit: RTL and testbench
===========================

CLA_NBIT -- requirements
Module: cla_nbit

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/sum width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have port A, input, N bits, addend A, two's-complement or unsigned.
REQ-005 SHALL have port B, input, N bits, addend B, two's-complement or unsigned.
REQ-006 SHALL have port Cin, input, 1 bit, carry-in added at bit 0.
REQ-007 SHALL have port S, output, N bits, registered sum.
REQ-008 SHALL have port Cout, output, 1 bit, registered carry out of bit N-1.
REQ-009 SHALL have port Ovf, output, 1 bit, registered signed overflow, present only when CLA_NBIT_OVF_EN is defined.

Function
REQ-010 SHALL compute {Cout,S} = A + B + Cin as an (N+1)-bit unsigned sum; S is the low N bits, Cout is bit N.
REQ-011 SHALL build the adder from 4-bit carry-lookahead groups: per-bit generate g=A&B, propagate p=A^B, and sum bit = p ^ carry.
REQ-012 SHALL produce each group's carries, group generate and group propagate from lookahead equations, with no ripple inside a group.
REQ-013 SHALL derive inter-group carries from a second-level lookahead unit over the group generate/propagate signals, with no ripple between groups.
REQ-014 SHALL keep the add path from A/B/Cin to the output registers purely combinational.
REQ-015 SHALL register S, Cout (and Ovf) on each rising clk edge, giving a latency of exactly 1 cycle; a new operand set is accepted every cycle.
REQ-016 SHALL ignore signedness internally; unsigned and two's-complement interpretations share the same bit result.
REQ-017 SHALL wrap around at the boundaries: all-ones + 0 + Cin=1 gives S=0, Cout=1; all-ones + all-ones + 1 gives S=all-ones, Cout=1.
REQ-018 SHALL raise Cout only for unsigned carry; signed overflow does not affect Cout.
REQ-019 SHALL reject an illegal N at elaboration time with a fatal error.

Reset
REQ-020 SHALL clear S, Cout and Ovf to 0 on a rising clk edge while rst_n=0.
REQ-021 SHALL give reset priority over the add result; operands present during reset are discarded.
REQ-022 SHALL show, on the first edge with rst_n=1, the sum of the operands present at that edge.
REQ-023 SHALL NOT act on rst_n asynchronously; an rst_n pulse between edges has no effect.

Configuration
REQ-024 SHALL, when macro CLA_NBIT_OVF_EN is defined, add output Ovf = carry into bit N-1 XOR carry out of bit N-1, registered with S.
REQ-025 SHALL, when CLA_NBIT_OVF_EN is not defined, omit port Ovf and its logic; all other behaviour is identical.

Verification (N=16, one cycle after apply)
REQ-026 SHALL check: A=10, B=20, Cin=0 -> S=30 (0x001E), Cout=0, Ovf=0.
REQ-027 SHALL check: A=-15 (0xFFF1), B=5, Cin=0 -> S=0xFFF6 (-10), Cout=0; and A=30, B=-10 (0xFFF6) -> S=20, Cout=1.
REQ-028 SHALL check: A=32767, B=1 -> S=0x8000, Cout=0, Ovf=1; and A=-32768, B=-1 -> S=0x7FFF, Cout=1, Ovf=1.
REQ-029 SHALL check: A=0xFFFF, B=0, Cin=1 -> S=0x0000, Cout=1, Ovf=0; and A=0xFFFF, B=0xFFFF, Cin=1 -> S=0xFFFF, Cout=1.
REQ-030 SHALL check: rst_n=0 held across an edge with A=1234, B=4321 -> S=0, Cout=0; rst_n=1 at the next edge -> S=5555.
REQ-031 SHALL check: back-to-back vectors on consecutive cycles, with outputs matching each vector exactly one cycle later, against a reference A+B+Cin over 10k random vectors.

Source files
------------

// File: rtl/cla_nbit.sv
// -----------------------------------------------------------------------------
// cla_nbit -- registered N-bit two-level carry-lookahead adder
//
// Computes {Cout,S} = A + B + Cin with one cycle of latency. The add path is
// built from 4-bit lookahead groups whose group generate/propagate feed a
// second-level lookahead unit, so no carry ripples inside or between groups.
// Signedness is irrelevant to the bit result; Cout is the unsigned carry.
//
// Parameters:
//   N      operand/sum width, multiple of 4 in 4..64 (default 16)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears S, Cout (and Ovf)
//   A, B   N-bit addends
//   Cin    carry into bit 0
//   S      registered N-bit sum
//   Cout   registered carry out of bit N-1
//   Ovf    registered signed overflow (only when CLA_NBIT_OVF_EN is defined)
//
// Optional feature macro: CLA_NBIT_OVF_EN
// -----------------------------------------------------------------------------
module cla_nbit #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
`ifdef CLA_NBIT_OVF_EN
    ,
    output logic         Ovf
`endif
);

    localparam int NG = N / 4;

    generate
        if ((N % 4) != 0 || N < 4 || N > 64) begin : g_bad_n
            $fatal(1, "cla_nbit: N=%0d is illegal (multiple of 4 in 4..64 required)", N);
        end
    endgenerate

    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;      // carry into each group; gc[NG] is the final carry
    logic [N:0]    carry;   // carry into each bit; carry[N] is the carry out
    logic [N-1:0]  sum_p0;

    logic [N-1:0]  sum_p1;
    logic          cout_p1;

    assign g = A & B;
    assign p = A ^ B;

    // Group generate/propagate, flattened over the four bits of each group.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < NG; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
    end

    // Second-level lookahead: every group carry is an independent
    // sum-of-products over Cin and the group terms. The loops only unroll
    // the product terms; no group carry is built from another.
    always_comb begin
        logic acc;
        logic t;
        acc   = 1'b0;
        t     = 1'b0;
        gc    = '0;
        gc[0] = Cin;
        for (int k = 1; k <= NG; k++) begin
            acc = Cin;
            for (int i = 0; i < k; i++) begin
                acc = acc & gp[i];
            end
            for (int j = 0; j < k; j++) begin
                t = gg[j];
                for (int i = j + 1; i < k; i++) begin
                    t = t & gp[i];
                end
                acc = acc | t;
            end
            gc[k] = acc;
        end
    end

    // In-group lookahead carries, each taken directly from the group carry-in.
    always_comb begin
        carry = '0;
        for (int k = 0; k < NG; k++) begin
            carry[4*k]   = gc[k];
            carry[4*k+1] = g[4*k]
                         | (p[4*k] & gc[k]);
            carry[4*k+2] = g[4*k+1]
                         | (p[4*k+1] & g[4*k])
                         | (p[4*k+1] & p[4*k] & gc[k]);
            carry[4*k+3] = g[4*k+2]
                         | (p[4*k+2] & g[4*k+1])
                         | (p[4*k+2] & p[4*k+1] & g[4*k])
                         | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        carry[N] = gc[NG];
    end

    assign sum_p0 = p ^ carry[N-1:0];

    // ---- stage boundary: p0 (combinational add) -> p1 (output registers) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
        end else begin
            sum_p1  <= sum_p0;
            cout_p1 <= carry[N];
        end
    end

    assign S    = sum_p1;
    assign Cout = cout_p1;

`ifdef CLA_NBIT_OVF_EN
    logic ovf_p1;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p1 <= 1'b0;
        end else begin
            ovf_p1 <= carry[N-1] ^ carry[N];
        end
    end

    assign Ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_cla_nbit.sv
// -----------------------------------------------------------------------------
// tb_cla_nbit -- self-checking bench for cla_nbit (N=16)
//
// Directed vectors with hand-computed sums, reset behaviour, then a
// back-to-back random run against A+B+Cin computed in the bench.
// -----------------------------------------------------------------------------
module tb_cla_nbit;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] S;
    logic         Cout;
`ifdef CLA_NBIT_OVF_EN
    logic         Ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;

    cla_nbit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout)
`ifdef CLA_NBIT_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "tb_cla_nbit: watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand set at a falling edge, let one rising edge register
    // it, and compare at the next falling edge.
    task automatic apply_chk(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic cin, input logic [N-1:0] exp_s, input logic exp_c,
                             input logic exp_o);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        @(negedge clk);
        check({tag, "/sum"},  64'(S),    64'(exp_s));
        check({tag, "/cout"}, 64'(Cout), 64'(exp_c));
`ifdef CLA_NBIT_OVF_EN
        check({tag, "/ovf"},  64'(Ovf),  64'(exp_o));
`else
        if (exp_o === 1'bx) $display("unused");
`endif
    endtask

    initial begin
        logic [N:0]   exp_prev;
        logic         ovf_prev;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;

        rst_n = 1'b0;
        A     = 16'h0ABC;
        B     = 16'h1234;
        Cin   = 1'b1;
        exp_prev = '0;
        ovf_prev = 1'b0;

        // Reset state with non-zero operands present.
        @(negedge clk);
        @(negedge clk);
        check("rst/sum",  64'(S),    64'h0);
        check("rst/cout", 64'(Cout), 64'h0);
`ifdef CLA_NBIT_OVF_EN
        check("rst/ovf",  64'(Ovf),  64'h0);
`endif

        // Reset discards operands; the first released edge shows their sum.
        A   = 16'd1234;
        B   = 16'd4321;
        Cin = 1'b0;
        @(negedge clk);
        check("rsthold/sum", 64'(S), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrel/sum",  64'(S),    64'd5555);
        check("rstrel/cout", 64'(Cout), 64'h0);

        rst_n = 1'b1;
        apply_chk("add10_20",   16'd10,   16'd20,   1'b0, 16'h001E, 1'b0, 1'b0);
        apply_chk("neg15_5",    16'hFFF1, 16'd5,    1'b0, 16'hFFF6, 1'b0, 1'b0);
        apply_chk("30_neg10",   16'd30,   16'hFFF6, 1'b0, 16'h0014, 1'b1, 1'b0);
        apply_chk("maxpos_1",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        apply_chk("minneg_m1",  16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        apply_chk("ones_0_c1",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        apply_chk("ones_ones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        apply_chk("zero",       16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        apply_chk("alt_c1",     16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0);
        apply_chk("grp_chain",  16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

        // An rst_n glitch between edges must not disturb the registers.
        A   = 16'd100;
        B   = 16'd200;
        Cin = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("glitch/hold", 64'(S), 64'd301);
        @(negedge clk);
        check("glitch/next", 64'(S), 64'd301);

        // Back-to-back random vectors, each checked one cycle later.
        for (int i = 0; i <= 10000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("rand/sum_cout", 64'({Cout, S}), 64'(exp_prev));
`ifdef CLA_NBIT_OVF_EN
                check("rand/ovf", 64'(Ovf), 64'(ovf_prev));
`endif
            end
            if (i < 10000) begin
                a   = N'($urandom);
                b   = N'($urandom);
                cin = 1'($urandom);
                if ((i % 7) == 3) a = '1;
                if ((i % 11) == 5) b = ~a;
                A   = a;
                B   = b;
                Cin = cin;
                if (i > 0 && i < 9) begin
                    #1;
                    check("rand/latency", 64'({Cout, S}), 64'(exp_prev));
                end
                exp_prev = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
                ovf_prev = (a[N-1] == b[N-1]) && (exp_prev[N-1] != a[N-1]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
